// File: rtl/persiana_pkg.sv
// Shared types and helpers for the blind position scheduler.
package persiana_pkg;

    typedef enum logic [1:0] {
        POS_INF = 2'b00,
        POS_MED = 2'b01,
        POS_SUP = 2'b10
    } pos_t;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'b00,
        SRC_MAN   = 2'b01,
        SRC_SCHED = 2'b10,
        SRC_AUTO  = 2'b11
    } src_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MOVE   = 2'b01,
        SETTLE = 2'b10,
        FAULT  = 2'b11
    } state_t;

    localparam logic [1:0] POS_INVALID = 2'b11;

    function automatic logic pos_valid(input logic [1:0] pos);
        return pos != POS_INVALID;
    endfunction

    // End sensor that confirms the given target position.
    function automatic logic at_target(input logic [1:0] pos, input logic s_sup,
                                       input logic s_med, input logic s_inf);
        logic hit;
        hit = 1'b0;
        case (pos)
            POS_INF: hit = s_inf;
            POS_MED: hit = s_med;
            POS_SUP: hit = s_sup;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/persiana_contador.sv
// Generic CW-bit counter with clear/load/enable, up or down, and a terminal flag.
module persiana_contador #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          load,
    input  logic          en,
    input  logic          down,
    input  logic [CW-1:0] load_val,
    input  logic [CW-1:0] limit,
    output logic          term_c
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over load, load wins over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = down ? cnt_q - CW'(1) : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_c = (cnt_q == limit);

endmodule

// File: rtl/persiana_planificador.sv
// Arbitrates manual/schedule/light requests into a position command for the blind FSM
// and supervises the resulting motion, latching a fault on timeout or sensor conflict.
module persiana_planificador
    import persiana_pkg::*;
#(
    parameter int unsigned HOLD_CYC        = 8,
    parameter int unsigned TIMEOUT_CYC     = 1000,
    parameter int unsigned MANUAL_LOCK_CYC = 5000,
    parameter int unsigned CW              = 16
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic       req_man_v,
    input  logic [1:0] req_man_pos,
    input  logic       req_sched_v,
    input  logic [1:0] req_sched_pos,
    input  logic       req_auto_v,
    input  logic [1:0] req_auto_pos,
    input  logic       subir,
    input  logic       bajar,
    input  logic       Ssup,
    input  logic       Smed,
    input  logic       Sinf,
    input  logic       fault_clr,
    output logic [1:0] P,
    output logic [1:0] grant,
    output logic [1:0] pos_actual,
    output logic       busy,
    output logic       fault
);

    state_t     state_q, state_d;
    logic [1:0] p_q, p_d;
    src_t       grant_q, grant_d;
    logic [1:0] pos_actual_q, pos_actual_d;
    logic       busy_q, busy_d;
    logic       fault_q, fault_d;

    logic       tmo_clr, tmo_en, tmo_term_c;
    logic       hold_clr, hold_en, hold_term_c;
    logic       lock_load, lock_zero_c;

    logic       win_v;
    src_t       win_src;
    logic [1:0] win_pos;
    logic       man_v;
    logic       conflict;
    logic       arrival;

    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        grant_d      = grant_q;
        pos_actual_d = pos_actual_q;
        tmo_clr      = 1'b0;
        tmo_en       = 1'b0;
        hold_clr     = 1'b0;
        hold_en      = 1'b0;
        lock_load    = 1'b0;
        win_v        = 1'b0;
        win_src      = SRC_NONE;
        win_pos      = req_man_pos;

        // Single winner; an invalid position kills it without falling through.
        if (req_man_v) begin
            win_v   = 1'b1;
            win_src = SRC_MAN;
            win_pos = req_man_pos;
        end else if (req_sched_v && lock_zero_c) begin
            win_v   = 1'b1;
            win_src = SRC_SCHED;
            win_pos = req_sched_pos;
        end else if (req_auto_v && lock_zero_c) begin
            win_v   = 1'b1;
            win_src = SRC_AUTO;
            win_pos = req_auto_pos;
        end
        win_v    = win_v && pos_valid(win_pos);
        man_v    = win_v && (win_src == SRC_MAN);
        conflict = (Ssup && Smed) || (Ssup && Sinf) || (Smed && Sinf);
        arrival  = at_target(p_q, Ssup, Smed, Sinf) && !subir && !bajar;

        case (state_q)
            IDLE: begin
                if (win_v && (win_pos != pos_actual_q)) begin
                    state_d   = MOVE;
                    p_d       = win_pos;
                    grant_d   = win_src;
                    tmo_clr   = 1'b1;
                    lock_load = (win_src == SRC_MAN);
                end
            end
            MOVE: begin
                if (conflict) begin
                    state_d = FAULT;
                    grant_d = SRC_NONE;
                end else if (arrival) begin
                    state_d      = SETTLE;
                    pos_actual_d = p_q;
                    hold_clr     = 1'b1;
                end else if (man_v && (win_pos != p_q)) begin
                    p_d       = win_pos;
                    grant_d   = SRC_MAN;
                    tmo_clr   = 1'b1;
                    lock_load = 1'b1;
                end else if (tmo_term_c) begin
                    state_d = FAULT;
                    grant_d = SRC_NONE;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            SETTLE: begin
                if (man_v && (win_pos != pos_actual_q)) begin
                    state_d   = MOVE;
                    p_d       = win_pos;
                    grant_d   = SRC_MAN;
                    tmo_clr   = 1'b1;
                    lock_load = 1'b1;
                end else if (hold_term_c) begin
                    state_d = IDLE;
                    grant_d = SRC_NONE;
                end else begin
                    hold_en = 1'b1;
                end
            end
            FAULT: begin
                grant_d = SRC_NONE;
                if (fault_clr) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d == MOVE) || (state_d == SETTLE);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            state_q      <= IDLE;
            p_q          <= 2'b00;
            grant_q      <= SRC_NONE;
            pos_actual_q <= 2'b00;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            grant_q      <= grant_d;
            pos_actual_q <= pos_actual_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
        end
    end

    persiana_contador #(.CW(CW)) u_tmo (
        .clk      (reloj),
        .reset    (reset),
        .clr      (tmo_clr),
        .load     (1'b0),
        .en       (tmo_en),
        .down     (1'b0),
        .load_val ('0),
        .limit    (CW'(TIMEOUT_CYC - 1)),
        .term_c   (tmo_term_c)
    );

    persiana_contador #(.CW(CW)) u_hold (
        .clk      (reloj),
        .reset    (reset),
        .clr      (hold_clr),
        .load     (1'b0),
        .en       (hold_en),
        .down     (1'b0),
        .load_val ('0),
        .limit    (CW'(HOLD_CYC - 1)),
        .term_c   (hold_term_c)
    );

    // Manual lock counts down to zero and stays there.
    persiana_contador #(.CW(CW)) u_lock (
        .clk      (reloj),
        .reset    (reset),
        .clr      (1'b0),
        .load     (lock_load),
        .en       (!lock_zero_c),
        .down     (1'b1),
        .load_val (CW'(MANUAL_LOCK_CYC)),
        .limit    ('0),
        .term_c   (lock_zero_c)
    );

    assign P          = p_q;
    assign grant      = grant_q;
    assign pos_actual = pos_actual_q;
    assign busy       = busy_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_persiana_planificador.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs, a monitor compares.
module tb_persiana_planificador;

    localparam int HOLD    = 4;
    localparam int TIMEOUT = 20;
    localparam int LOCK    = 50;

    typedef struct packed {
        logic [1:0] p;
        logic [1:0] grant;
        logic [1:0] pos;
        logic       busy;
        logic       fault;
    } exp_t;

    logic       reloj = 1'b0;
    logic       reset = 1'b1;
    logic       req_man_v = 1'b0, req_sched_v = 1'b0, req_auto_v = 1'b0;
    logic [1:0] req_man_pos = 2'b00, req_sched_pos = 2'b00, req_auto_pos = 2'b00;
    logic       subir = 1'b0, bajar = 1'b0;
    logic       Ssup = 1'b0, Smed = 1'b0, Sinf = 1'b0;
    logic       fault_clr = 1'b0;
    logic [1:0] P, grant, pos_actual;
    logic       busy, fault;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t exp_q[$];

    // Model state: mode 0 idle, 1 moving, 2 settling, 3 faulted.
    int         m_mode = 0;
    logic [1:0] m_p = 2'b00, m_grant = 2'b00, m_pos = 2'b00;
    int         m_age = 0;
    int         m_lock = 0;

    persiana_planificador #(
        .HOLD_CYC(HOLD), .TIMEOUT_CYC(TIMEOUT), .MANUAL_LOCK_CYC(LOCK), .CW(16)
    ) dut (
        .reloj(reloj), .reset(reset),
        .req_man_v(req_man_v), .req_man_pos(req_man_pos),
        .req_sched_v(req_sched_v), .req_sched_pos(req_sched_pos),
        .req_auto_v(req_auto_v), .req_auto_pos(req_auto_pos),
        .subir(subir), .bajar(bajar), .Ssup(Ssup), .Smed(Smed), .Sinf(Sinf),
        .fault_clr(fault_clr),
        .P(P), .grant(grant), .pos_actual(pos_actual), .busy(busy), .fault(fault)
    );

    always #5 reloj = ~reloj;

    task automatic check_val(input string what, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b", what, got, want);
        end
    endtask

    task automatic start_move(input logic [1:0] src, input logic [1:0] pos, output bit manual);
        m_mode  = 1;
        m_p     = pos;
        m_grant = src;
        m_age   = 0;
        manual  = (src == 2'b01);
    endtask

    task automatic model_step();
        bit         have, reload, arrived, lock_on;
        logic [1:0] wsrc, wpos;
        int         nsens;
        if (reset) begin
            m_mode = 0; m_p = 2'b00; m_grant = 2'b00; m_pos = 2'b00; m_age = 0; m_lock = 0;
            return;
        end
        lock_on = (m_lock > 0);
        reload  = 1'b0;
        have    = 1'b0;
        wsrc    = 2'b00;
        wpos    = 2'b00;
        if (req_man_v) begin
            have = 1'b1; wsrc = 2'b01; wpos = req_man_pos;
        end else if (req_sched_v && !lock_on) begin
            have = 1'b1; wsrc = 2'b10; wpos = req_sched_pos;
        end else if (req_auto_v && !lock_on) begin
            have = 1'b1; wsrc = 2'b11; wpos = req_auto_pos;
        end
        if (wpos == 2'b11) have = 1'b0;
        nsens = int'(Ssup) + int'(Smed) + int'(Sinf);
        case (m_p)
            2'b00:   arrived = Sinf;
            2'b01:   arrived = Smed;
            2'b10:   arrived = Ssup;
            default: arrived = 1'b0;
        endcase
        arrived = arrived && !subir && !bajar;
        case (m_mode)
            0: if (have && wpos != m_pos) start_move(wsrc, wpos, reload);
            1: begin
                if (nsens >= 2) begin
                    m_mode = 3; m_grant = 2'b00;
                end else if (arrived) begin
                    m_pos = m_p; m_mode = 2; m_age = 0;
                end else if (have && wsrc == 2'b01 && wpos != m_p) begin
                    start_move(wsrc, wpos, reload);
                end else begin
                    m_age++;
                    if (m_age == TIMEOUT) begin
                        m_mode = 3; m_grant = 2'b00;
                    end
                end
            end
            2: begin
                if (have && wsrc == 2'b01 && wpos != m_pos) begin
                    start_move(wsrc, wpos, reload);
                end else begin
                    m_age++;
                    if (m_age == HOLD) begin
                        m_mode = 0; m_grant = 2'b00;
                    end
                end
            end
            default: if (fault_clr) m_mode = 0;
        endcase
        if (reload) m_lock = LOCK;
        else if (m_lock > 0) m_lock--;
    endtask

    // Apply current inputs for one clock, queue the prediction, then drop the pulses.
    task automatic tick();
        exp_t e;
        model_step();
        e.p     = m_p;
        e.grant = m_grant;
        e.pos   = m_pos;
        e.busy  = (m_mode == 1) || (m_mode == 2);
        e.fault = (m_mode == 3);
        exp_q.push_back(e);
        @(negedge reloj);
        req_man_v = 1'b0; req_sched_v = 1'b0; req_auto_v = 1'b0;
        fault_clr = 1'b0; reset = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sensors(input logic sup, input logic med, input logic inf,
                           input logic up, input logic dn);
        Ssup = sup; Smed = med; Sinf = inf; subir = up; bajar = dn;
    endtask

    task automatic random_cycle();
        int s;
        req_man_v     = ($urandom_range(99) < 4);
        req_man_pos   = 2'($urandom_range(3));
        req_sched_v   = ($urandom_range(99) < 10);
        req_sched_pos = 2'($urandom_range(3));
        req_auto_v    = ($urandom_range(99) < 10);
        req_auto_pos  = 2'($urandom_range(3));
        fault_clr     = ($urandom_range(99) < 8);
        reset         = ($urandom_range(999) < 3);
        s = int'($urandom_range(99));
        sensors(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (s < 60) begin
            if ($urandom_range(1) == 0) subir = 1'b1; else bajar = 1'b1;
        end else if (s < 94) begin
            case (m_p)
                2'b00:   Sinf = 1'b1;
                2'b01:   Smed = 1'b1;
                default: Ssup = 1'b1;
            endcase
            if (s >= 88) subir = 1'b1;
        end else begin
            {Ssup, Smed, Sinf} = 3'($urandom_range(7));
        end
        tick();
    endtask

    // Monitor: every cycle the DUT presents a full output word to compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge reloj);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc++;
                checks++;
                if (P !== e.p || grant !== e.grant || pos_actual !== e.pos ||
                    busy !== e.busy || fault !== e.fault) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d got P=%b grant=%b pos=%b busy=%b fault=%b want P=%b grant=%b pos=%b busy=%b fault=%b",
                             cyc, P, grant, pos_actual, busy, fault,
                             e.p, e.grant, e.pos, e.busy, e.fault);
                end
            end
        end
    end

    initial begin
        @(negedge reloj);
        // Reset, then light sensor to top and arrival.
        reset = 1'b1; tick(); reset = 1'b1; tick();
        check_val("reset_state", {P, grant, pos_actual, busy, fault}, 8'h00);
        req_auto_v = 1'b1; req_auto_pos = 2'b10; tick();
        sensors(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); ticks(5);
        sensors(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); ticks(6);

        // Simultaneous requests; manual wins and locks out the schedule.
        req_man_v = 1'b1; req_man_pos = 2'b01;
        req_sched_v = 1'b1; req_sched_pos = 2'b00;
        req_auto_v = 1'b1; req_auto_pos = 2'b10; tick();
        sensors(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); ticks(2);
        sensors(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); ticks(7);
        req_sched_v = 1'b1; req_sched_pos = 2'b10; tick();
        ticks(45);
        req_sched_v = 1'b1; req_sched_pos = 2'b10; tick();
        sensors(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); ticks(2);
        sensors(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); ticks(6);

        // Manual pre-emption mid-move.
        sensors(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1; tick();
        req_auto_v = 1'b1; req_auto_pos = 2'b10; tick();
        sensors(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); ticks(4);
        req_man_v = 1'b1; req_man_pos = 2'b00; tick();
        sensors(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); ticks(3);
        sensors(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); ticks(6);

        // Timeout with no sensor response, requests ignored, clear beats request.
        req_man_v = 1'b1; req_man_pos = 2'b01; tick();
        sensors(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) begin
                req_sched_v = 1'b1; req_sched_pos = 2'b10;
                req_auto_v = 1'b1; req_auto_pos = 2'b00;
            end
            if (i > 20) begin
                req_man_v = 1'b1; req_man_pos = 2'b10;
            end
            tick();
            if (i == 18) check_val("timeout_early", {7'b0, fault}, 8'h00);
            if (i == 19) check_val("timeout_expired", {7'b0, fault}, 8'h01);
        end
        check_val("fault_held", {5'b0, grant, fault}, 8'h01);
        fault_clr = 1'b1; req_man_v = 1'b1; req_man_pos = 2'b10; tick();
        ticks(3);

        // Sensor conflict, then invalid positions in IDLE.
        sensors(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1; tick();
        req_auto_v = 1'b1; req_auto_pos = 2'b01; tick();
        sensors(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        sensors(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ticks(2);
        fault_clr = 1'b1; tick();
        req_man_v = 1'b1; req_man_pos = 2'b11; tick();
        req_sched_v = 1'b1; req_sched_pos = 2'b11; tick();
        req_auto_v = 1'b1; req_auto_pos = 2'b11; tick();
        ticks(2);

        // Reset during a move.
        req_auto_v = 1'b1; req_auto_pos = 2'b10; tick();
        sensors(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); ticks(3);
        reset = 1'b1; tick();
        ticks(2);

        for (int i = 0; i < 1500; i++) random_cycle();

        @(posedge reloj);
        @(posedge reloj);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
